cpu_if_queue: RTL
=================

# cpu_if_queue

Parametrised instruction-fetch stage with a decoupling instruction queue between the instruction cache and the decoder. It issues sequential fetch requests to the Icache over a valid/ready handshake and keeps at most one request outstanding. Returned instructions are byte-swapped and pushed into a DEPTH-entry FIFO together with their PC. Branch and jump redirects flush the queue and squash any in-flight response, and an optional predecode mode halts fetch after a control-transfer instruction until the redirect arrives.

## Interface
- ADDR_W, 32, PC / address width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, fetch address after reset
- SWAP_BYTES, 1, 1 = deliver {b0,b1,b2,b3} of the Icache word (endianness fix); 0 = pass through
- STALL_ON_CTRL, 1, 1 = stop issuing after queueing JAL/JALR/branch until a redirect
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; low freezes all state
- ic_req_valid  out  1  fetch request
- ic_req_addr  out  ADDR_W  fetch address (current pc)
- ic_req_ready  in  1  Icache accepts request
- ic_resp_valid  in  1  instruction returned for the outstanding request
- ic_resp_inst  in  32  raw instruction word
- br_valid  in  1  branch resolved; redirect, highest priority
- br_addr  in  ADDR_W  branch target / fall-through
- jmp_valid  in  1  jump resolved; redirect
- jmp_addr  in  ADDR_W  jump target
- deq_valid  out  1  queue head valid
- deq_ready  in  1  decoder takes head
- deq_pc  out  ADDR_W  PC of head
- deq_inst  out  32  (swapped) instruction of head
- count  out  clog2(DEPTH)+1  entries held

## Operation
- State: pc, circular buffer {pc,inst}×DEPTH, rd/wr pointers, count, outstanding, req_pc, drop, ctrl_stall.
- Redirect = br_valid | jmp_valid; target = br_valid ? br_addr : jmp_addr.
- ic_req_valid = rst_n & rdy & ~redirect & ~ctrl_stall & (count + outstanding < DEPTH) & (~outstanding | ic_resp_valid).
- Request handshake (ic_req_valid & ic_req_ready): req_pc <= pc, pc <= pc + 4 (mod 2^ADDR_W), outstanding <= 1, drop <= 0.
- Response with outstanding & ~drop & ~redirect: push {req_pc, swapped inst}. If STALL_ON_CTRL and inst[6:0] ∈ {1101111, 1100111, 1100011}, set ctrl_stall. Here inst is the swapped word.
- Response with drop or redirect: discarded. outstanding clears unless a new request is accepted in the same cycle.
- ic_resp_valid with outstanding = 0 is ignored.
- deq_valid = rdy & ~redirect & (count != 0). Pop on deq_valid & deq_ready. Simultaneous push and pop keeps count unchanged.
- Redirect cycle:
  - count, rd, wr <= 0; pc <= target; ctrl_stall <= 0.
  - If a request is outstanding and no response arrives this cycle: drop <= 1.
  - Queue contents and any same-cycle response are lost.
- The backend asserts br_valid for every resolved branch (taken or not) and jmp_valid for every jump. This is the only way ctrl_stall clears.
- rdy low: no state changes; ic_req_valid and deq_valid low. The Icache is gated by the same rdy.

## Timing
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC; count = 0; outstanding = drop = ctrl_stall = 0; storage cleared.
  - ic_req_valid = 0, ic_req_addr = RESET_PC, deq_valid = 0, deq_pc = 0, deq_inst = 0, count = 0.
- First request: ic_req_valid is high in the first cycle after rst_n rises, with rdy high.
- Redirect at edge t: ic_req_valid is low during cycle t; a request to the target is issued in cycle t+1.
- Fetch latency: response at cycle t+k is available at deq in cycle t+k+1.
- Throughput: a new request may be accepted in the response cycle. With a 1-cycle Icache and a non-stalling decoder, the block sustains 1 instr/cycle.
- Full: no request is issued when count + outstanding = DEPTH. The queue never overflows.
- Empty: deq_valid stays low and deq_ready is ignored.
- Pointers wrap modulo DEPTH. pc wraps 0xFFFFFFFC → 0x0.

## Test plan
- Sequential fetch, DEPTH=4, 1-cycle Icache, deq_ready=1: deq_pc sequence 0x0, 0x4, 0x8…, one per cycle from cycle 3; SWAP_BYTES: resp 0x13000000 → deq_inst 0x00000013.
- Decoder stalled (deq_ready=0): exactly 4 entries accepted, count=4, ic_req_valid stays 0. Release → order preserved, no duplicates or loss.
- JAL (swapped 0x0080006F) fetched at 0x8: no request after 0xC. jmp_valid, jmp_addr=0x100 → queue flushed, next ic_req_addr=0x100.
- Redirect while a request is outstanding (br_addr=0x40) with response 2 cycles later: stale response discarded, first deq_pc=0x40.
- br_valid and jmp_valid in the same cycle (0x80 vs 0x200): fetch resumes at 0x80.
- rst_n pulsed low mid-stream, asynchronously between edges: outputs reach reset values immediately; fetch restarts at RESET_PC. rdy held low for 5 cycles: count and pc are unchanged.

Source files
------------

// File: rtl/cpu_if_queue.sv
// Instruction-fetch stage: sequential Icache requests (one outstanding) feeding a
// DEPTH-entry {pc, inst} queue; branch/jump redirects flush the queue and squash fetches.
module cpu_if_queue #(
  parameter int unsigned       ADDR_W        = 32,
  parameter int unsigned       DEPTH         = 4,
  parameter logic [ADDR_W-1:0] RESET_PC      = '0,
  parameter bit                SWAP_BYTES    = 1'b1,
  parameter bit                STALL_ON_CTRL = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  output logic                     ic_req_valid,
  output logic [ADDR_W-1:0]        ic_req_addr,
  input  logic                     ic_req_ready,
  input  logic                     ic_resp_valid,
  input  logic [31:0]              ic_resp_inst,
  input  logic                     br_valid,
  input  logic [ADDR_W-1:0]        br_addr,
  input  logic                     jmp_valid,
  input  logic [ADDR_W-1:0]        jmp_addr,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [ADDR_W-1:0]        deq_pc,
  output logic [31:0]              deq_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic is_ctrl_op(input logic [6:0] op);
    logic r;
    case (op)
      7'b1101111, 7'b1100111, 7'b1100011: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] req_pc_r;
  logic              outstanding_r;
  logic              drop_r;
  logic              ctrl_stall_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [ADDR_W-1:0] mem_pc_r   [DEPTH];
  logic [31:0]       mem_inst_r [DEPTH];

  logic              redirect_s;
  logic [ADDR_W-1:0] target_s;
  logic [31:0]       resp_inst_s;
  logic [OCC_W-1:0]  occupancy_s;
  logic              ic_req_valid_s;
  logic              req_fire_s;
  logic              resp_seen_s;
  logic              push_s;
  logic              deq_valid_s;
  logic              pop_s;

  // Handshake decode; a response may free the slot for a request in the same cycle
  always_comb begin
    redirect_s     = br_valid | jmp_valid;
    target_s       = br_valid ? br_addr : jmp_addr;
    resp_inst_s    = SWAP_BYTES ? byte_swap(ic_resp_inst) : ic_resp_inst;
    occupancy_s    = OCC_W'(count_r) + OCC_W'(outstanding_r);
    ic_req_valid_s = rst_n & rdy & ~redirect_s & ~ctrl_stall_r &
                     (occupancy_s < OCC_W'(DEPTH)) & (~outstanding_r | ic_resp_valid);
    req_fire_s     = ic_req_valid_s & ic_req_ready;
    resp_seen_s    = rdy & outstanding_r & ic_resp_valid;
    push_s         = resp_seen_s & ~drop_r & ~redirect_s;
    deq_valid_s    = rdy & ~redirect_s & (count_r != '0);
    pop_s          = deq_valid_s & deq_ready;
  end

  // Fetch pointer, outstanding/drop tracking and control-transfer stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r          <= RESET_PC;
      req_pc_r      <= '0;
      outstanding_r <= 1'b0;
      drop_r        <= 1'b0;
      ctrl_stall_r  <= 1'b0;
    end else if (rdy) begin
      if (redirect_s) begin
        pc_r <= target_s;
      end else if (req_fire_s) begin
        pc_r <= pc_r + ADDR_W'(4);
      end
      if (req_fire_s) begin
        req_pc_r      <= pc_r;
        outstanding_r <= 1'b1;
        drop_r        <= 1'b0;
      end else if (resp_seen_s) begin
        outstanding_r <= 1'b0;
        drop_r        <= 1'b0;
      end else if (redirect_s && outstanding_r) begin
        // the response still owed for the old path must be thrown away
        drop_r <= 1'b1;
      end
      if (redirect_s) begin
        ctrl_stall_r <= 1'b0;
      end else if (push_s && STALL_ON_CTRL && is_ctrl_op(resp_inst_s[6:0])) begin
        ctrl_stall_r <= 1'b1;
      end
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (rdy) begin
      if (redirect_s) begin
        rd_ptr_r <= '0;
        wr_ptr_r <= '0;
        count_r  <= '0;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
        end
        count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      end
    end
  end

  // Queue storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_pc_r[i]   <= '0;
        mem_inst_r[i] <= '0;
      end
    end else if (rdy && push_s) begin
      mem_pc_r[wr_ptr_r]   <= req_pc_r;
      mem_inst_r[wr_ptr_r] <= resp_inst_s;
    end
  end

  assign ic_req_valid = ic_req_valid_s;
  assign ic_req_addr  = pc_r;
  assign deq_valid    = deq_valid_s;
  assign deq_pc       = mem_pc_r[rd_ptr_r];
  assign deq_inst     = mem_inst_r[rd_ptr_r];
  assign count        = count_r;

endmodule
